periph_bus_arbiter: RTL and testbench
=====================================

// Module: periph_bus_arbiter
// PURPOSE
//  Shares the peripheral register bus (UART, USB SIE regs) between two masters: m0 = RV32I CPU, m1 = SPI-IO bridge.
//  Serialises single-word accesses with fair round-robin arbitration.
//  Drives one-cycle s_rd/s_wr strobes, captures s_rdata and returns a one-cycle ack to the winning master.
//  Sits between the masters and the existing m_sel/m_addr/m_rd/m_wr peripheral decode.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width
//  SETUP_CYCLES 0   extra address-setup cycles before the strobe (0..15)
// PORTS
//  clk_48m   in   1   system clock, 48 MHz
//  rstn      in   1   reset, synchronous, active-low
//  m0_req    in   1   m0 access request; hold high with addr/wdata/wr stable until m0_ack
//  m0_wr     in   1   1 = write, 0 = read
//  m0_addr   in   AW  byte address
//  m0_wdata  in   DW  write data
//  m0_lock   in   1   hold bus across back-to-back accesses (ARB_LOCK_EN only)
//  m0_rdata  out  DW  read data, valid while m0_ack = 1, held until next m0 read
//  m0_ack    out  1   one-cycle completion pulse
//  m1_*      same set as m0_*, for master 1
//  s_addr    out  AW  address to peripheral decode
//  s_wdata   out  DW  write data to peripherals
//  s_rd      out  1   one-cycle read strobe
//  s_wr      out  1   one-cycle write strobe
//  s_rdata   in   DW  combinational read data from the peripheral mux
//  owner     out  1   master currently granted (valid while busy)
//  busy      out  1   1 in any state other than IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM = IDLE; last_grant = 1 (m0 wins the first tie). Reset mid-access aborts: no ack, no strobe.
//  - FSM states and transitions:
//    IDLE   -> SETUP when any req is high; latch owner, addr, wdata and wr.
//    SETUP  lasts SETUP_CYCLES cycles; skipped when SETUP_CYCLES = 0.
//    STROBE exactly one cycle: s_rd or s_wr high per latched wr; s_rdata registered into owner's rdata.
//    ACK    owner's ack high one cycle -> IDLE.
//  - Latency: req sampled in IDLE -> ack in cycle 3 + SETUP_CYCLES (IDLE=0).
//  - Bus outputs while not in SETUP or STROBE:
//    s_rd/s_wr are 0.
//    s_addr/s_wdata hold their last values (no glitching into decode).
//  - Arbitration:
//    Only one master requests: that master wins.
//    Both request in IDLE: winner = ~last_grant; last_grant updates on grant.
//    Consequence: under continuous dual requests, grants alternate strictly 0,1,0,1.
//  - req is level-sensitive, sampled only in IDLE.
//    Master drops req at the edge where it sees ack. A req still high in IDLE is a new access.
//  - Non-owner req is ignored until IDLE; it is never lost while held.
//  - Write data and address are latched at grant. Changes by the master mid-access have no effect.
//  - m_rdata updates only on reads; writes leave it unchanged.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//    If the owner's lock is high during ACK and its req is high in the following IDLE,
//    the owner is re-granted regardless of the other master.
//    last_grant is not toggled by locked re-grants. Lock low restores round-robin.
//  ARB_LOCK_EN undefined:
//    m*_lock inputs are ignored (ports remain, unconnected logic); pure round-robin.
// TESTING
//  1. Reset: rstn=0 for 2 cycles -> all outputs 0, busy=0; m0 read addr 0x2000_0008, s_rdata=0x1234 -> m0_ack at cycle 3, m0_rdata=0x1234.
//  2. Simultaneous m0/m1 writes (0x2100_0000 <= 0xA5, 0x2000_0000 <= 0x41) held 4 accesses -> s_wr owners 0,1,0,1, one strobe each, no overlap.
//  3. SETUP_CYCLES=2: m1 read -> s_addr valid 2 cycles before s_rd; m1_ack at cycle 5; s_rd high exactly 1 cycle.
//  4. rstn=0 during STROBE of m0 write -> no m0_ack, s_wr=0 next cycle; after release, m0 req wins (last_grant=1).
//  5. ARB_LOCK_EN: m0_lock=1, 3 back-to-back m0 reads while m1_req=1 -> three m0 acks first, then m1 granted on lock drop.
//  6. Mid-access, m0 changes addr/wdata while granted -> s_addr/s_wdata keep latched values until ack.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register bus: one single-word access at a time.
// Optional ARB_LOCK_EN: the owner's lock lets it keep the bus across back-to-back accesses.
module periph_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int SETUP_CYCLES = 0
) (
  input  logic          clk_48m,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_rd,
  output logic          s_wr,
  input  logic [DW-1:0] s_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  localparam logic [3:0] SETUP_LAST = (SETUP_CYCLES == 0) ? 4'd0 : 4'(SETUP_CYCLES - 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       wr_q;
  logic [3:0] setup_cnt;
  logic       any_req;
  logic       win;
  logic       lock_re;

`ifdef ARB_LOCK_EN
  logic lock_q;
  // lock_q is only ever set for the IDLE cycle directly following the owner's ACK
  assign lock_re = lock_q & (owner ? m1_req : m0_req);
`else
  logic unused_lock;
  assign unused_lock = m0_lock | m1_lock;
  assign lock_re     = 1'b0;
`endif

  assign any_req = m0_req | m1_req;

  always_comb begin
    win = m1_req;
    if (lock_re)               win = owner;
    else if (m0_req && m1_req) win = ~last_grant;
  end

  always_ff @(posedge clk_48m) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (any_req) state_nxt = (SETUP_CYCLES == 0) ? STROBE : SETUP;
      SETUP:  if (setup_cnt == SETUP_LAST) state_nxt = STROBE;
      STROBE: state_nxt = ACK;
      ACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48m) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wr_q       <= 1'b0;
      setup_cnt  <= 4'd0;
      s_addr     <= '0;
      s_wdata    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= win;
        wr_q      <= win ? m1_wr    : m0_wr;
        s_addr    <= win ? m1_addr  : m0_addr;
        s_wdata   <= win ? m1_wdata : m0_wdata;
        setup_cnt <= 4'd0;
        if (!lock_re) last_grant <= win;
      end
      if (state == SETUP) setup_cnt <= setup_cnt + 4'd1;
      if (state == STROBE && !wr_q) begin
        if (owner) m1_rdata <= s_rdata;
        else       m0_rdata <= s_rdata;
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk_48m) begin
    if (!rstn)              lock_q <= 1'b0;
    else if (state == ACK)  lock_q <= owner ? m1_lock : m0_lock;
    else if (state == IDLE) lock_q <= 1'b0;
  end
`endif

  // bus strobes and acks decode straight from the registered state, so they never glitch
  assign s_rd   = (state == STROBE) & ~wr_q;
  assign s_wr   = (state == STROBE) &  wr_q;
  assign m0_ack = (state == ACK) & ~owner;
  assign m1_ack = (state == ACK) &  owner;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: vector table plus hand-written multi-cycle sequences.
// Latency is counted as the rising edge (after req is raised) at which the master sees ack.
module tb_periph_bus_arbiter;

  logic        clk_48m = 1'b0;
  logic        rstn;
  always #10 clk_48m = ~clk_48m;

  // DUT a: SETUP_CYCLES = 0
  logic        m0_req, m0_wr, m0_lock, m0_ack, m1_req, m1_wr, m1_lock, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_rd, s_wr, owner, busy;

  // DUT b: SETUP_CYCLES = 2
  logic        b_m0_req, b_m0_wr, b_m0_ack, b_m1_req, b_m1_wr, b_m1_ack;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_s_rd, b_s_wr, b_owner, b_busy;

  periph_bus_arbiter #(.AW(32), .DW(32), .SETUP_CYCLES(0)) dut_a (
    .clk_48m(clk_48m), .rstn(rstn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr), .s_rdata(s_rdata),
    .owner(owner), .busy(busy));

  periph_bus_arbiter #(.AW(32), .DW(32), .SETUP_CYCLES(2)) dut_b (
    .clk_48m(clk_48m), .rstn(rstn),
    .m0_req(b_m0_req), .m0_wr(b_m0_wr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_lock(1'b0),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_wr(b_m1_wr), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_lock(1'b0),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rd(b_s_rd), .s_wr(b_s_wr), .s_rdata(b_s_rdata),
    .owner(b_owner), .busy(b_busy));

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [31:0] rdata;
    logic        win;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl_rd0 = 32'h0;
  logic [31:0] mdl_rd1 = 32'h0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_48m);
    @(negedge clk_48m);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk_48m);
    @(negedge clk_48m);
    rstn = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n, strobes, ack_at;
    logic        ack_who, saw_wr, str_own, both_ack;
    logic        exp_wr;
    logic [31:0] sa, sd, exp_a, exp_d;
    n = 0; strobes = 0; ack_at = 0; ack_who = 0; saw_wr = 0; str_own = 0; both_ack = 0;
    sa = 0; sd = 0;
    m0_req = v.r0; m0_wr = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_wr = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    s_rdata = v.rdata;
    while (ack_at == 0 && n < 20) begin
      cyc();
      n++;
      if (s_rd || s_wr) begin
        strobes++; saw_wr = s_wr; sa = s_addr; sd = s_wdata; str_own = owner;
      end
      if (m0_ack || m1_ack) begin
        ack_at = n + 1; ack_who = m1_ack; both_ack = m0_ack & m1_ack;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    exp_wr = v.win ? v.w1 : v.w0;
    exp_a  = v.win ? v.a1 : v.a0;
    exp_d  = v.win ? v.d1 : v.d0;
    if (!exp_wr) begin
      if (v.win) mdl_rd1 = v.rdata;
      else       mdl_rd0 = v.rdata;
    end
    chk($sformatf("v%0d ack_latency", idx), 64'(ack_at), 64'd3);
    chk($sformatf("v%0d ack_master", idx), {63'd0, ack_who}, {63'd0, v.win});
    chk($sformatf("v%0d ack_both", idx), {63'd0, both_ack}, 64'd0);
    chk($sformatf("v%0d strobe_count", idx), 64'(strobes), 64'd1);
    chk($sformatf("v%0d strobe_kind", idx), {63'd0, saw_wr}, {63'd0, exp_wr});
    chk($sformatf("v%0d strobe_owner", idx), {63'd0, str_own}, {63'd0, v.win});
    chk($sformatf("v%0d s_addr", idx), {32'd0, sa}, {32'd0, exp_a});
    if (exp_wr) chk($sformatf("v%0d s_wdata", idx), {32'd0, sd}, {32'd0, exp_d});
    chk($sformatf("v%0d m0_rdata", idx), {32'd0, m0_rdata}, {32'd0, mdl_rd0});
    chk($sformatf("v%0d m1_rdata", idx), {32'd0, m1_rdata}, {32'd0, mdl_rd1});
    cyc();
    chk($sformatf("v%0d idle_busy", idx), {63'd0, busy}, 64'd0);
  endtask

  vec_t vt[8];

  initial begin
    int   n, k, strobes, dbl, rd_seen, a0n, a1n, rd_first, rd_cnt, ack_at;
    logic prev;
    logic own_seq[4];
    logic ack_seq[4];
    logic exp_seq[4];

    // {r0, w0, a0, d0, r1, w1, a1, d1, s_rdata, expected winner}; last_grant starts at 1
    vt[0] = '{1'b1, 1'b0, 32'h2000_0008, 32'h0,  1'b0, 1'b0, 32'h0,         32'h0,  32'h0000_1234, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b1, 32'h2000_0000, 32'h41, 32'h0,         1'b1};
    vt[2] = '{1'b1, 1'b1, 32'h2100_0000, 32'hA5, 1'b1, 1'b0, 32'h2000_0010, 32'h0,  32'h55,        1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h2100_0004, 32'h0,  1'b1, 1'b0, 32'h2000_0010, 32'h0,  32'h66,        1'b1};
    vt[4] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 32'h2000_0020, 32'h0,  32'hDEAD_BEEF, 1'b1};
    vt[5] = '{1'b1, 1'b0, 32'h2000_000C, 32'h0,  1'b1, 1'b1, 32'h2000_0004, 32'h99, 32'h0000_CAFE, 1'b0};
    vt[6] = '{1'b1, 1'b1, 32'h2100_0008, 32'h5A, 1'b0, 1'b0, 32'h0,         32'h0,  32'h1111,      1'b0};
    vt[7] = '{1'b1, 1'b1, 32'h2000_0000, 32'h1,  1'b1, 1'b1, 32'h2000_0018, 32'h2,  32'h0,         1'b1};

    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    s_rdata = 0;
    b_m0_req = 0; b_m0_wr = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_wr = 0; b_m1_addr = 0; b_m1_wdata = 0;
    b_s_rdata = 0;

    // reset state, sampled while rstn is still low
    rstn = 1'b0;
    repeat (2) @(posedge clk_48m);
    @(negedge clk_48m);
    chk("reset ctl", {58'd0, busy, owner, s_rd, s_wr, m0_ack, m1_ack}, 64'd0);
    chk("reset bus", {s_addr, s_wdata}, 64'd0);
    chk("reset rdata", {m0_rdata, m1_rdata}, 64'd0);
    rstn = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // continuous dual writes: strict alternation starting at m0 after reset
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h2100_0000; m0_wdata = 32'hA5;
    m1_req = 1; m1_wr = 1; m1_addr = 32'h2000_0000; m1_wdata = 32'h41;
    n = 0; k = 0; strobes = 0; dbl = 0; rd_seen = 0; a0n = 0; a1n = 0; prev = 0;
    for (int i = 0; i < 4; i++) own_seq[i] = 1'bx;
    while ((a0n + a1n) < 4 && n < 40) begin
      cyc();
      n++;
      if (s_rd) rd_seen++;
      if (s_wr && prev) dbl++;
      prev = s_wr;
      if (s_wr) begin
        if (k < 4) own_seq[k] = owner;
        k++;
        chk("rr s_addr", {32'd0, s_addr}, {32'd0, owner ? 32'h2000_0000 : 32'h2100_0000});
      end
      if (m0_ack) a0n++;
      if (m1_ack) a1n++;
    end
    m0_req = 0; m1_req = 0;
    chk("rr owners", {60'd0, own_seq[0], own_seq[1], own_seq[2], own_seq[3]}, 64'b0101);
    chk("rr strobes", 64'(k), 64'd4);
    chk("rr overlap", 64'(dbl), 64'd0);
    chk("rr no s_rd", 64'(rd_seen), 64'd0);
    chk("rr acks", {32'(a0n), 32'(a1n)}, {32'd2, 32'd2});
    cyc();

    // reset during STROBE of an m0 write aborts it; m0 then wins against m1
    m0_req = 1; m0_wr = 1; m0_addr = 32'h2000_0040; m0_wdata = 32'h77;
    cyc();
    chk("abort strobe", {63'd0, s_wr}, 64'd1);
    rstn = 1'b0;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h2000_0044;
    cyc();
    chk("abort outputs", {61'd0, m0_ack, s_wr, busy}, 64'd0);
    rstn = 1'b1;
    cyc();
    chk("abort regrant", {62'd0, busy, owner}, 64'b10);
    ack_at = 0; n = 1;
    while (ack_at == 0 && n < 20) begin
      cyc();
      n++;
      if (m0_ack || m1_ack) ack_at = m1_ack ? 2 : 1;
    end
    m0_req = 0; m1_req = 0;
    chk("abort ack m0", 64'(ack_at), 64'd1);
    cyc();

    // lock: m0 holds lock for three reads while m1 waits
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h2000_0008; m0_lock = 1;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h2000_000C;
    s_rdata = 32'h42;
    n = 0; k = 0; a0n = 0;
    while (k < 4 && n < 60) begin
      cyc();
      n++;
      if (m0_ack || m1_ack) begin
        ack_seq[k] = m1_ack;
        k++;
      end
      if (m0_ack) begin
        a0n++;
        if (a0n == 3) begin m0_req = 0; m0_lock = 0; end
      end
    end
    m0_req = 0; m0_lock = 0; m1_req = 0;
`ifdef ARB_LOCK_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    chk("lock ack count", 64'(k), 64'd4);
    chk("lock ack order", {60'd0, ack_seq[0], ack_seq[1], ack_seq[2], ack_seq[3]},
        {60'd0, exp_seq[0], exp_seq[1], exp_seq[2], exp_seq[3]});
    cyc();

    // SETUP_CYCLES = 2: address two cycles ahead of a single-cycle read strobe
    b_m1_req = 1; b_m1_wr = 0; b_m1_addr = 32'h2000_0014; b_s_rdata = 32'h0000_0077;
    n = 0; ack_at = 0; rd_first = 0; rd_cnt = 0;
    while (ack_at == 0 && n < 20) begin
      cyc();
      n++;
      if (n == 1) chk("setup early addr", {32'd0, b_s_addr}, 64'h2000_0014);
      if (b_s_rd) begin
        if (rd_cnt == 0) rd_first = n;
        rd_cnt++;
      end
      if (b_m1_ack) ack_at = n + 1;
    end
    b_m1_req = 0;
    chk("setup s_rd pos", 64'(rd_first), 64'd3);
    chk("setup s_rd width", 64'(rd_cnt), 64'd1);
    chk("setup ack latency", 64'(ack_at), 64'd5);
    chk("setup m1_rdata", {32'd0, b_m1_rdata}, 64'h77);
    cyc();

    // master changes addr/wdata mid-access: latched values stay on the bus
    b_m0_req = 1; b_m0_wr = 1; b_m0_addr = 32'h2000_0100; b_m0_wdata = 32'h1111_2222;
    n = 0; ack_at = 0;
    while (ack_at == 0 && n < 20) begin
      cyc();
      n++;
      if (n == 1) begin b_m0_addr = 32'hFFFF_FFFC; b_m0_wdata = 32'h0; end
      if (b_s_wr) chk("latch at strobe", {b_s_addr, b_s_wdata}, 64'h2000_0100_1111_2222);
      if (b_m0_ack) ack_at = n + 1;
    end
    b_m0_req = 0;
    chk("latch ack latency", 64'(ack_at), 64'd5);
    cyc();
    chk("hold after ack", {b_s_addr, b_s_wdata}, 64'h2000_0100_1111_2222);
    chk("hold strobes idle", {62'd0, b_s_rd, b_s_wr}, 64'd0);
    chk("write keeps rdata", {32'd0, b_m0_rdata}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
